store_buffer: RTL and testbench

- Write-through store buffer between the MEM-stage store path and the data-memory bus.
- Consumes the selected store data, i.e. the output of the D-cache data-in select (EXE/MEM rs2 data or WB forwarded data), together with the store address and byte enables.
- Queues stores in a FIFO and drains them in order to memory over a req/ack handshake.
- Flags loads whose word address matches a pending store so the pipeline can stall.

---
 rtl/store_buffer.sv | 159 +++++++++++++++
 tb/tb_store_buffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Write-through store buffer: in-order FIFO drain to memory, load word-hazard detect.
// Optional STORE_BUF_FWD_EN: full-word forwarding from the youngest matching entry.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      st_valid,
  input  logic [ADDR_W-1:0]         st_addr,
  input  logic [DATA_W-1:0]         st_data,
  input  logic [DATA_W/8-1:0]       st_be,
  output logic                      st_ready,
  input  logic                      ld_valid,
  input  logic [ADDR_W-1:0]         ld_addr,
  output logic                      ld_hazard,
  output logic                      ld_fwd_hit,
  output logic [DATA_W-1:0]         ld_fwd_data,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_data,
  output logic [DATA_W/8-1:0]       mem_be,
  input  logic                      mem_ack,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                      empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int BW = DATA_W / 8;

  typedef enum logic {IDLE, SEND} state_t;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [BW-1:0]     r_be   [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PW-1:0]     r_wr;
  logic [PW-1:0]     r_rd;
  logic [CW-1:0]     r_count;
  logic              r_empty;
  state_t            r_state;
  logic              r_req;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_any;
  logic [1:0]    w_unused_ld;

  assign w_unused_ld = ld_addr[1:0];

  assign st_ready  = (r_count != CW'(DEPTH));
  assign w_push    = st_valid && st_ready;
  assign w_pop     = r_req && mem_ack;
  assign w_cnt_nxt = r_count + CW'(w_push) - CW'(w_pop);

  assign count = r_count;
  assign empty = r_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr] <= st_addr;
      r_data[r_wr] <= st_data;
      r_be[r_wr]   <= st_be;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) begin
        r_vld[r_wr] <= 1'b1;
        r_wr        <= r_wr + PW'(1);
      end
      if (w_pop) begin
        r_vld[r_rd] <= 1'b0;
        r_rd        <= r_rd + PW'(1);
      end
      r_count <= w_cnt_nxt;
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  // Drain FSM; mem_req is the registered image of SEND
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (r_count != '0) begin
            r_state <= SEND;
            r_req   <= 1'b1;
          end
        end
        SEND: begin
          if (w_pop && (w_cnt_nxt == '0)) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req  = r_req;
  assign mem_addr = r_req ? r_addr[r_rd] : '0;
  assign mem_data = r_req ? r_data[r_rd] : '0;
  assign mem_be   = r_req ? r_be[r_rd]   : '0;

`ifdef STORE_BUF_FWD_EN
  logic              w_y_full;
  logic [DATA_W-1:0] w_y_data;

  // Walk oldest to youngest so the last match wins
  always_comb begin
    w_any    = 1'b0;
    w_y_full = 1'b0;
    w_y_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_vld[r_rd + PW'(k)] &&
          (r_addr[r_rd + PW'(k)][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
        w_any    = 1'b1;
        w_y_full = &r_be[r_rd + PW'(k)];
        w_y_data = r_data[r_rd + PW'(k)];
      end
    end
  end

  assign ld_fwd_hit  = ld_valid && w_any && w_y_full;
  assign ld_fwd_data = ld_fwd_hit ? w_y_data : '0;
  assign ld_hazard   = ld_valid && w_any && !w_y_full;
`else
  always_comb begin
    w_any = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_vld[k] && (r_addr[k][ADDR_W-1:2] == ld_addr[ADDR_W-1:2]))
        w_any = 1'b1;
    end
  end

  assign ld_fwd_hit  = 1'b0;
  assign ld_fwd_data = '0;
  assign ld_hazard   = ld_valid && w_any;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer.
// Inputs change 1ns after posedge; checks happen before the next edge.
module tb_store_buffer;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        ld_fwd_hit;
  logic [31:0] ld_fwd_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [2:0]  count;
  logic        empty;

  int n_pass = 0;
  int n_tot  = 0;

  store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_be(st_be), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_be(mem_be), .mem_ack(mem_ack),
    .count(count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] b);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_be    = b;
  endtask

  task automatic drain(input string tag);
    mem_ack  = 1'b1;
    st_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (empty) break;
      cyc();
    end
    mem_ack = 1'b0;
    chk(tag, empty, 1);
  endtask

  initial begin
    rst = 1'b1;
    st_valid = 0; st_addr = 0; st_data = 0; st_be = 0;
    ld_valid = 0; ld_addr = 0; mem_ack = 0;
    #12;
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ready", st_ready, 1);
    chk("rst_haz", ld_hazard, 0);
    chk("rst_fwd", {ld_fwd_hit, ld_fwd_data}, 0);
    rst = 1'b0;

    // 1: single store, held without ack
    cyc();
    st(32'h100, 32'hDEADBEEF, 4'hF);
    cyc();
    st_valid = 0;
    chk("t1_count", count, 1);
    chk("t1_empty", empty, 0);
    cyc();
    chk("t1_req", mem_req, 1);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_data", mem_data, 32'hDEADBEEF);
    chk("t1_be", mem_be, 4'hF);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t1_hold", {mem_req, mem_addr, mem_data, count},
          {1'b1, 32'h100, 32'hDEADBEEF, 3'd1});
    end
    mem_ack = 1;
    cyc();
    mem_ack = 0;
    chk("t1_empty_after", empty, 1);
    chk("t1_idle", mem_req, 0);

    // 2: fill, drop 5th, drain in order
    for (int i = 0; i < 4; i++) begin
      st(32'(4 * i), 32'hA0 + 32'(i), 4'hF);
      cyc();
    end
    st(32'h10, 32'hBAD, 4'hF);
    chk("t2_ready", st_ready, 0);
    chk("t2_count", count, 4);
    cyc();
    st_valid = 0;
    chk("t2_drop", count, 4);
    mem_ack = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_req", mem_req, 1);
      chk("t2_addr", mem_addr, 32'(4 * i));
      chk("t2_data", mem_data, 32'hA0 + 32'(i));
      cyc();
    end
    mem_ack = 0;
    chk("t2_empty", empty, 1);
    chk("t2_idle", mem_req, 0);
    cyc();
    chk("t2_no5th", mem_req, 0);

    // 3: push+pop same cycle with pointer wrap
    st(32'h40, 32'h1, 4'hF);
    cyc();
    st(32'h44, 32'h2, 4'hF);
    cyc();
    chk("t3_count2", count, 2);
    chk("t3_head0", mem_addr, 32'h40);
    st(32'h48, 32'h3, 4'hF);
    mem_ack = 1;
    cyc();
    chk("t3_cnt_a", count, 2);
    chk("t3_head1", {mem_addr, mem_data}, {32'h44, 32'h2});
    st(32'h4C, 32'h4, 4'hF);
    cyc();
    st_valid = 0;
    chk("t3_cnt_b", count, 2);
    chk("t3_head2", {mem_addr, mem_data}, {32'h48, 32'h3});
    cyc();
    chk("t3_cnt_c", count, 1);
    chk("t3_head3", {mem_addr, mem_data}, {32'h4C, 32'h4});
    cyc();
    mem_ack = 0;
    chk("t3_empty", empty, 1);
    chk("t3_idle", mem_req, 0);

    // 4: word hazard (partial store so both builds flag it)
    st(32'h200, 32'h12345678, 4'h3);
    cyc();
    st_valid = 0;
    ld_valid = 1;
    ld_addr  = 32'h202;
    #1 chk("t4_haz_same", ld_hazard, 1);
    ld_addr = 32'h204;
    #1 chk("t4_haz_next", ld_hazard, 0);
    ld_addr  = 32'h200;
    ld_valid = 0;
    #1 chk("t4_haz_noval", ld_hazard, 0);
    drain("t4_drain");

    // 5: reset mid-SEND
    for (int i = 0; i < 3; i++) begin
      st(32'h400 + 32'(4 * i), 32'(i), 4'hF);
      cyc();
    end
    st_valid = 0;
    cyc();
    chk("t5_req", mem_req, 1);
    chk("t5_cnt", count, 3);
    #2 rst = 1;
    #1;
    chk("t5_rst_req", mem_req, 0);
    chk("t5_rst_cnt", count, 0);
    chk("t5_rst_empty", empty, 1);
    chk("t5_rst_ready", st_ready, 1);
    #2 rst = 0;
    cyc();
    st(32'h500, 32'h55, 4'hF);
    cyc();
    st_valid = 0;
    cyc();
    chk("t5_post_req", mem_req, 1);
    chk("t5_post_addr", {mem_addr, mem_data}, {32'h500, 32'h55});
    mem_ack = 1;
    cyc();
    mem_ack = 0;
    chk("t5_post_empty", empty, 1);

    // 6: forwarding
    st(32'h300, 32'h11111111, 4'hF);
    cyc();
    st(32'h300, 32'h22222222, 4'hF);
    cyc();
    st_valid = 0;
    ld_valid = 1;
    ld_addr  = 32'h300;
    #1;
`ifdef STORE_BUF_FWD_EN
    chk("t6_hit", ld_fwd_hit, 1);
    chk("t6_data", ld_fwd_data, 32'h22222222);
    chk("t6_haz", ld_hazard, 0);
`else
    chk("t6_hit", ld_fwd_hit, 0);
    chk("t6_data", ld_fwd_data, 0);
    chk("t6_haz", ld_hazard, 1);
`endif
    ld_valid = 0;
    drain("t6_drain_a");
    st(32'h300, 32'h11111111, 4'hF);
    cyc();
    st(32'h300, 32'h0000AAAA, 4'h3);
    cyc();
    st_valid = 0;
    ld_valid = 1;
    #1;
    chk("t6_part_haz", ld_hazard, 1);
    chk("t6_part_hit", ld_fwd_hit, 0);
    ld_valid = 0;
    drain("t6_drain_b");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
